// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        fault_t      fault;
    } rsp_t;

    // Misalignment outranks range: a misaligned out-of-range PC reports 01.
    function automatic fault_t classify(input logic [31:0] addr, input int unsigned aw);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ((addr >> aw) != 32'd0) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/imem_responder_sync_fifo.sv
// Generic synchronous FIFO, DEPTH need not be a power of two; reads are zero-latency from the head.
// Writes when full and reads when empty are ignored; the caller's credit scheme keeps them from occurring.
module sync_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_wr = wr_en_i && (count_q != CW'(DEPTH));
    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order word fetch with fault flagging; response LATENCY cycles after accept.
// Accepts while fewer than LATENCY+1 responses are outstanding and no program load is active; never drops.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [1:0]            rsp_fault,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-3:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);
    localparam int DEPTH = LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [31:0] mem_q [WORDS];

    logic        accept;
    fault_t      lkp_fault;
    rsp_t        lkp;
    logic        fifo_wr;
    rsp_t        fifo_wdat;
    logic [$bits(rsp_t)-1:0] fifo_rdat;
    rsp_t        head;
    logic        fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] pipe_cnt;
    logic [CW-1:0] outstanding;

    // Storage has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (ld_valid) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        lkp_fault = classify(req_addr, ADDR_WIDTH);
        lkp.fault = lkp_fault;
        lkp.data  = (lkp_fault == FAULT_NONE) ? mem_q[req_addr[ADDR_WIDTH-1:2]] : NOP_INSN;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_wr   = accept;
            assign fifo_wdat = lkp;
            assign pipe_cnt  = '0;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;

            rsp_t              pipe_q [STAGES];
            logic [STAGES-1:0] pipe_vld_q;

            // Stages never stall: the credit limit guarantees the FIFO has room on arrival.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld_q <= '0;
                end else begin
                    pipe_vld_q[0] <= accept;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe_vld_q[i] <= pipe_vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipe_q[0] <= lkp;
                for (int i = 1; i < STAGES; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end

            always_comb begin
                pipe_cnt = '0;
                for (int i = 0; i < STAGES; i++) begin
                    pipe_cnt = pipe_cnt + CW'(pipe_vld_q[i]);
                end
            end

            assign fifo_wr   = pipe_vld_q[STAGES-1];
            assign fifo_wdat = pipe_q[STAGES-1];
        end
    endgenerate

    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (fifo_wdat),
        .rd_en_i  (rsp_valid && rsp_ready),
        .rd_dat_o (fifo_rdat),
        .empty_o  (fifo_empty),
        .count_o  (fifo_cnt)
    );

    // Only registered state feeds req_ready, so a consume frees a slot one cycle later.
    assign outstanding = fifo_cnt + pipe_cnt;
    assign req_ready   = !ld_valid && (outstanding < CW'(LATENCY + 1));

    assign head      = rsp_t'(fifo_rdat);
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = rsp_valid ? head.data : 32'h0;
    assign rsp_fault = rsp_valid ? head.fault : FAULT_NONE;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the RISC-V core: the memory end of the fetch interface. It accepts word fetch requests by byte address over a valid/ready handshake and returns instruction words in order with fixed latency, flagging misaligned and out-of-range addresses. A load port writes program words before or between runs. It sits between the fetch stage and the instruction storage array.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte-address bits decoded; storage depth is 2^(ADDR_WIDTH-2) 32-bit words.
- `LATENCY`, 2: cycles from request accept to `rsp_valid`; legal range 1..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: responder can accept a request.
- `req_addr` in 32: fetch byte address (PC).
- `rsp_valid` out 1: response word present.
- `rsp_ready` in 1: fetch stage consumes the response.
- `rsp_data` out 32: instruction word.
- `rsp_fault` out 2: 00 ok, 01 misaligned, 10 out of range.
- `ld_valid` in 1: program-load write this cycle.
- `ld_addr` in ADDR_WIDTH-2: load word index.
- `ld_data` in 32: load word.

## Operation
- Accept: `req_valid && req_ready` at a rising edge.
- `req_ready` = !`ld_valid` && outstanding < LATENCY+1. Outstanding = accepted, not yet consumed by `rsp_valid && rsp_ready`.
- Word index = `req_addr[ADDR_WIDTH-1:2]`.
- Fault rules, checked in priority order:
  - `req_addr[1:0] != 0` gives fault 01.
  - Else any bit of `req_addr[31:ADDR_WIDTH]` set gives fault 10.
  - Else fault 00.
  - Any fault forces `rsp_data` = 32'h0000_0013 (NOP). A fault response still takes a slot and completes normally.
- Responses are returned strictly in acceptance order. Each response is held stable while `rsp_valid && !rsp_ready`.
- Response buffer holds LATENCY+1 entries. A full buffer deasserts `req_ready`; it never drops or overwrites a response.
- Load writes take priority over fetch: a write in cycle t is visible to a fetch accepted in cycle t+1 or later. Fetches already in flight return the old data.
- Storage is not cleared by reset.

## Timing
- Reset values: `req_ready`=1 (when `ld_valid`=0), `rsp_valid`=0, `rsp_data`=0, `rsp_fault`=00, outstanding=0.
- Latency: an accept at edge t gives `rsp_valid`=1 in the cycle after edge t+LATENCY-1, provided earlier responses have been consumed.
- Throughput: with `rsp_ready` held at 1, one request is accepted and one response delivered every cycle.
- Backpressure: with `rsp_ready`=0, exactly LATENCY+1 requests are accepted, then `req_ready`=0.
- Simultaneous consume and accept when full: `req_ready` follows the registered count, so no accept occurs in that cycle. `req_ready` rises the cycle after the consume.
- `rst` mid-operation: all in-flight and buffered responses are discarded. `rsp_valid`=0 in the cycle after the reset edge. Storage contents are kept.

## Structure
- Package `imem_pkg` holds:
  - fault codes `FAULT_NONE`, `FAULT_MISALIGN`, `FAULT_RANGE`;
  - `NOP_INSN` = 32'h0000_0013;
  - a packed response struct {data, fault}.
- Sub-module `sync_fifo`, parameterised by width and depth, buffers responses. The read pipeline of LATENCY-1 stages sits in front of it, and its count drives `req_ready`.

## Test plan
- Load words 0..3 with 0xA0..0xA3, then fetch addresses 0,4,8,12 back-to-back with `rsp_ready`=1. Expect A0..A3 on four consecutive cycles, first one LATENCY cycles after the first accept.
- Fetch 0x6 and then 0x0001_0000 (ADDR_WIDTH=16). Expect fault 01 and fault 10 respectively, both with data 0x0000_0013, in order.
- Hold `rsp_ready`=0 and drive `req_valid`=1. Expect exactly LATENCY+1 accepts, then `req_ready`=0. Release `rsp_ready` and expect all responses in order with no loss.
- Assert `ld_valid` with `req_valid`. Expect `req_ready`=0 that cycle, then a fetch of the same word next cycle returns the new data.
- Assert `rst` with 2 responses outstanding. Expect `rsp_valid`=0 after the reset edge, outstanding=0, and previously loaded words still readable.
